// File: rtl/waveform_pkg.sv
// Shared types and constants for the waveform capture front end.
// The capture FSM states and the trigger-mode encoding used by cfg_trig.
package waveform_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    DRAIN
  } cap_state_e;

  localparam logic [1:0] TRIG_IMM  = 2'b00;
  localparam logic [1:0] TRIG_RISE = 2'b01;
  localparam logic [1:0] TRIG_FALL = 2'b10;
  localparam logic [1:0] TRIG_ANY  = 2'b11;

endpackage

// File: rtl/waveform_sample_timer.sv
// Channel mux, edge detector and sample-rate divider for waveform_capture.
// The divider counter is parked unless run is set or the owner forces a load.
module waveform_sample_timer
  import waveform_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sig_in,
  input  logic [2:0]       chan,
  input  logic [1:0]       trig,
  input  logic [DIV_W-1:0] div,
  input  logic             trig_en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  output logic             sample_bit,
  output logic             tick,
  output logic             hit
);

  logic             s_d;
  logic             rise;
  logic             fall;
  logic             trig_match;
  logic [DIV_W-1:0] cnt;

  assign sample_bit = sig_in[chan];
  assign rise       = sample_bit & ~s_d;
  assign fall       = ~sample_bit & s_d;

  always_comb begin
    trig_match = 1'b0;
    case (trig)
      TRIG_RISE: trig_match = rise;
      TRIG_FALL: trig_match = fall;
      TRIG_ANY:  trig_match = rise | fall;
      default:   trig_match = 1'b0;
    endcase
  end

  assign hit  = trig_en & trig_match;
  assign tick = run & (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_d <= 1'b0;
      cnt <= '0;
    end else begin
      s_d <= sample_bit;
      if (load) begin
        cnt <= load_val;
      end else if (run) begin
        cnt <= tick ? div : cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/waveform_capture.sv
// Single-channel logic capture: optional edge trigger, divided sample rate,
// 8 samples per byte (MSB oldest), then a valid/ready drain of the whole buffer.
module waveform_capture
  import waveform_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sig_in,
  input  logic [2:0]       cfg_chan,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_trig,
  input  logic             arm,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int unsigned PW = $clog2(NUM_BYTES);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_BYTES - 1);

  cap_state_e       state;
  logic [2:0]       chan_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       trig_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       new_byte;
  logic [7:0]       mem [NUM_BYTES];

  logic             start;
  logic [2:0]       chan_sel;
  logic             sample_bit;
  logic             tick;
  logic             hit;
  logic             sample_en;
  logic             byte_done;
  logic             last_wr;

  assign start     = (state == IDLE) & arm & ~abort;
  // In IDLE the live channel feeds the edge history so WAIT_TRIG starts on a clean s_d.
  assign chan_sel  = (state == IDLE) ? cfg_chan : chan_q;
  assign sample_en = tick | hit;
  assign new_byte  = {shreg[6:0], sample_bit};
  assign byte_done = sample_en & (bit_cnt == 3'd7);
  assign last_wr   = byte_done & (wr_ptr == LAST_IDX);
  assign rd_nxt    = rd_ptr + 1'b1;
  assign busy      = (state != IDLE);

  waveform_sample_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .chan       (chan_sel),
    .trig       (trig_q),
    .div        (div_q),
    .trig_en    (state == WAIT_TRIG),
    .load       (start | hit),
    .load_val   (start ? '0 : div_q),
    .run        (state == CAPTURE),
    .sample_bit (sample_bit),
    .tick       (tick),
    .hit        (hit)
  );

  always_ff @(posedge clk) begin
    if (rst_n && !abort && byte_done) begin
      mem[wr_ptr] <= new_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
      chan_q    <= '0;
      div_q     <= '0;
      trig_q    <= TRIG_IMM;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else if (abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            done    <= 1'b0;
            chan_q  <= cfg_chan;
            div_q   <= cfg_div;
            trig_q  <= cfg_trig;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            bit_cnt <= '0;
            state   <= (cfg_trig == TRIG_IMM) ? CAPTURE : WAIT_TRIG;
          end
        end
        WAIT_TRIG, CAPTURE: begin
          if (sample_en) begin
            shreg   <= new_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (state == WAIT_TRIG) begin
              state <= CAPTURE;
            end
            if (last_wr) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_data  <= mem[0];
              out_last  <= 1'b0;
            end else if (byte_done) begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              rd_ptr   <= rd_nxt;
              out_data <= mem[rd_nxt];
              out_last <= (rd_nxt == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_capture.sv
// Randomized bench for waveform_capture: probe history is recorded per cycle and the
// expected byte stream and drain timing are rebuilt from it after each capture.
module tb_waveform_capture;

  localparam int NB = 16;
  localparam int DW = 16;
  localparam int HN = 65536;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    sig_in = 8'h00;
  logic [2:0]    cfg_chan = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [1:0]    cfg_trig = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int         cyc = 0;
  logic [7:0] hist [HN];
  int         sig_mode = 0;
  int         pat_cnt = 0;
  int         arm_cyc = 0;

  logic [7:0] exp_b [NB];
  int         exp_vcyc;
  logic [7:0] got_b [NB];
  logic       got_l [NB];
  int         got_n, first_vcyc, viol, extra;

  waveform_capture #(
    .NUM_BYTES (NB),
    .DIV_W     (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_trig  (cfg_trig),
    .arm       (arm),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // hist[c] is the probe value the DUT sees at rising edge number c.
  always @(posedge clk) begin
    hist[cyc] = sig_in;
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    logic [7:0] r;
    r = 8'($urandom);
    case (sig_mode)
      1: r[2] = ~sig_in[2];
      2: begin
        r[0] = (pat_cnt >= 50) && (((pat_cnt - 50) % 8) < 4);
        pat_cnt++;
      end
      default: ;
    endcase
    if (sig_mode != 2) pat_cnt = 0;
    sig_in = r;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic do_arm(input int ch, input int dv, input int tg);
    @(negedge clk);
    cfg_chan = 3'(ch);
    cfg_div  = DW'(dv);
    cfg_trig = 2'(tg);
    arm      = 1'b1;
    arm_cyc  = cyc;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Expected bytes from the recorded probe history and the sampling rules.
  task automatic model_capture(input int a, input int ch, input int dv, input int tg);
    int t, first, idx;
    logic cur, prv;
    logic [7:0] b;
    first = a + 1;
    if (tg != 0) begin
      t = a + 1;
      while (t < cyc) begin
        cur = hist[t][ch];
        prv = hist[t-1][ch];
        if ((tg == 1 && cur && !prv) || (tg == 2 && !cur && prv) || (tg == 3 && cur != prv))
          break;
        t++;
      end
      first = t;
    end
    for (int i = 0; i < NB; i++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
        idx = first + (8 * i + j) * (dv + 1);
        b = {b[6:0], (idx < HN) ? hist[idx][ch] : 1'b0};
      end
      exp_b[i] = b;
    end
    exp_vcyc = first + (8 * NB - 1) * (dv + 1) + 1;
  endtask

  // mode 0: always ready; 1: 5-cycle stall on byte 3 then random; 2: stop before byte 7.
  task automatic collect(input int mode, input int max_cyc);
    logic stalled, pl, r;
    logic [7:0] pd;
    int stall_cnt, limit;
    got_n = 0; first_vcyc = -1; viol = 0; extra = 0;
    stalled = 1'b0; pd = 8'h00; pl = 1'b0; stall_cnt = 0;
    limit = (mode == 2) ? 7 : NB;
    for (int k = 0; k < max_cyc && got_n < limit; k++) begin
      @(negedge clk);
      if (stalled && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) viol++;
      if (out_valid === 1'b1 && first_vcyc < 0) first_vcyc = cyc;
      r = 1'b1;
      if (mode == 1) begin
        if (out_valid === 1'b1 && got_n == 3 && stall_cnt < 5) begin
          r = 1'b0;
          stall_cnt++;
        end else begin
          r = 1'($urandom_range(0, 1));
        end
      end
      out_ready = r;
      stalled = (out_valid === 1'b1) && !r;
      pd = out_data;
      pl = out_last;
      if (out_valid === 1'b1 && r) begin
        got_b[got_n] = out_data;
        got_l[got_n] = out_last;
        got_n++;
      end
    end
    if (mode != 2) begin
      out_ready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (out_valid === 1'b1) extra++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_tests += 5;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (out_last !== 1'b0)  begin n_fail++; $display("FAIL rst_last: got %b expected 0", out_last); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %02h expected 00", out_data); end
  endtask

  task automatic test_immediate;
    sig_mode = 1;
    do_arm(2, 0, 0);
    collect(0, 400);
    model_capture(arm_cyc, 2, 0, 0);
    n_tests++;
    if (got_n !== NB) begin n_fail++; $display("FAIL imm_count: got %0d expected %0d", got_n, NB); end
    for (int i = 0; i < got_n; i++) begin
      n_tests += 3;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL imm_byte[%0d]: got %02h expected %02h", i, got_b[i], exp_b[i]);
      end
      if (got_b[i] !== 8'hAA && got_b[i] !== 8'h55) begin
        n_fail++; $display("FAIL imm_pattern[%0d]: got %02h expected AA or 55", i, got_b[i]);
      end
      if (got_l[i] !== (i == NB - 1)) begin
        n_fail++; $display("FAIL imm_last[%0d]: got %b expected %b", i, got_l[i], i == NB - 1);
      end
    end
    n_tests += 4;
    if (first_vcyc !== exp_vcyc) begin
      n_fail++; $display("FAIL imm_drain_cycle: got %0d expected %0d", first_vcyc, exp_vcyc);
    end
    if (extra !== 0)     begin n_fail++; $display("FAIL imm_extra: got %0d expected 0", extra); end
    if (done !== 1'b1)   begin n_fail++; $display("FAIL imm_done: got %b expected 1", done); end
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL imm_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rise_trigger;
    sig_mode = 2;
    do_arm(0, 0, 1);
    repeat (10) @(negedge clk);
    n_tests += 2;
    if (busy !== 1'b1)      begin n_fail++; $display("FAIL trig_wait_busy: got %b expected 1", busy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL trig_wait_valid: got %b expected 0", out_valid); end
    collect(0, 600);
    model_capture(arm_cyc, 0, 0, 1);
    n_tests += 3;
    if (got_n !== NB) begin n_fail++; $display("FAIL trig_count: got %0d expected %0d", got_n, NB); end
    if (got_b[0] !== 8'hF0) begin n_fail++; $display("FAIL trig_first: got %02h expected F0", got_b[0]); end
    if (first_vcyc !== exp_vcyc) begin
      n_fail++; $display("FAIL trig_drain_cycle: got %0d expected %0d", first_vcyc, exp_vcyc);
    end
    for (int i = 0; i < got_n; i++) begin
      n_tests++;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL trig_byte[%0d]: got %02h expected %02h", i, got_b[i], exp_b[i]);
      end
    end
    sig_mode = 0;
  endtask

  task automatic test_divider;
    int ch;
    ch = $urandom_range(0, 7);
    sig_mode = 0;
    do_arm(ch, 3, 0);
    collect(0, 1000);
    model_capture(arm_cyc, ch, 3, 0);
    n_tests += 3;
    if (got_n !== NB) begin n_fail++; $display("FAIL div_count: got %0d expected %0d", got_n, NB); end
    // First tick one cycle after arm, 128 samples 4 cycles apart, valid visible one cycle later.
    if (first_vcyc !== arm_cyc + 1 + 127 * 4 + 1) begin
      n_fail++; $display("FAIL div_drain_cycle: got %0d expected %0d", first_vcyc, arm_cyc + 510);
    end
    if (first_vcyc !== exp_vcyc) begin
      n_fail++; $display("FAIL div_model_cycle: got %0d expected %0d", first_vcyc, exp_vcyc);
    end
    for (int i = 0; i < got_n; i++) begin
      n_tests++;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL div_byte[%0d]: got %02h expected %02h", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int ch, dv;
    ch = $urandom_range(0, 7);
    dv = $urandom_range(0, 2);
    do_arm(ch, dv, 0);
    collect(1, 3000);
    model_capture(arm_cyc, ch, dv, 0);
    n_tests += 3;
    if (got_n !== NB) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_n, NB); end
    if (viol !== 0)   begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", viol); end
    if (extra !== 0)  begin n_fail++; $display("FAIL bp_extra: got %0d expected 0", extra); end
    for (int i = 0; i < got_n; i++) begin
      n_tests += 2;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL bp_byte[%0d]: got %02h expected %02h", i, got_b[i], exp_b[i]);
      end
      if (got_l[i] !== (i == NB - 1)) begin
        n_fail++; $display("FAIL bp_last[%0d]: got %b expected %b", i, got_l[i], i == NB - 1);
      end
    end
  endtask

  task automatic test_arm_ignored;
    int ch;
    ch = $urandom_range(0, 7);
    do_arm(ch, 1, 0);
    repeat (30) @(negedge clk);
    cfg_chan = 3'(ch + 1);
    cfg_div  = '0;
    cfg_trig = 2'b01;
    arm      = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    collect(0, 1000);
    model_capture(arm_cyc, ch, 1, 0);
    n_tests += 2;
    if (got_n !== NB) begin n_fail++; $display("FAIL ign_count: got %0d expected %0d", got_n, NB); end
    if (first_vcyc !== exp_vcyc) begin
      n_fail++; $display("FAIL ign_drain_cycle: got %0d expected %0d", first_vcyc, exp_vcyc);
    end
    for (int i = 0; i < got_n; i++) begin
      n_tests++;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL ign_byte[%0d]: got %02h expected %02h", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_abort;
    int ch, seen;
    ch = $urandom_range(0, 7);
    do_arm(ch, 0, 0);
    repeat (44) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests += 3;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", out_valid); end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    arm = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    abort = 1'b0;
    n_tests += 2;
    if (seen !== 0)    begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL arm_abort_busy: got %b expected 0", busy); end
    do_arm(ch, 0, 0);
    collect(0, 400);
    model_capture(arm_cyc, ch, 0, 0);
    n_tests += 2;
    if (got_n !== NB)  begin n_fail++; $display("FAIL rearm_count: got %0d expected %0d", got_n, NB); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL rearm_done: got %b expected 1", done); end
    for (int i = 0; i < got_n; i++) begin
      n_tests++;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL rearm_byte[%0d]: got %02h expected %02h", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_drain;
    int ch;
    ch = $urandom_range(0, 7);
    do_arm(ch, 0, 0);
    collect(2, 400);
    model_capture(arm_cyc, ch, 0, 0);
    n_tests++;
    if (got_n !== 7) begin n_fail++; $display("FAIL rd_partial_count: got %0d expected 7", got_n); end
    for (int i = 0; i < got_n; i++) begin
      n_tests++;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL rd_partial[%0d]: got %02h expected %02h", i, got_b[i], exp_b[i]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_tests += 5;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rd_busy: got %b expected 0", busy); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL rd_done: got %b expected 0", done); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid: got %b expected 0", out_valid); end
    if (out_last !== 1'b0)  begin n_fail++; $display("FAIL rd_last: got %b expected 0", out_last); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL rd_data: got %02h expected 00", out_data); end
    rst_n = 1'b1;
    ch = $urandom_range(0, 7);
    do_arm(ch, 0, 0);
    collect(0, 400);
    model_capture(arm_cyc, ch, 0, 0);
    n_tests++;
    if (got_n !== NB) begin n_fail++; $display("FAIL rd_clean_count: got %0d expected %0d", got_n, NB); end
    for (int i = 0; i < got_n; i++) begin
      n_tests++;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL rd_clean[%0d]: got %02h expected %02h", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_random;
    int ch, dv, tg;
    for (int it = 0; it < 4; it++) begin
      ch = $urandom_range(0, 7);
      dv = $urandom_range(0, 3);
      tg = $urandom_range(0, 3);
      do_arm(ch, dv, tg);
      collect(1, 2500);
      model_capture(arm_cyc, ch, dv, tg);
      n_tests += 3;
      if (got_n !== NB) begin
        n_fail++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, got_n, NB);
      end
      if (viol !== 0) begin
        n_fail++; $display("FAIL rnd%0d_stable: got %0d changes expected 0", it, viol);
      end
      if (first_vcyc !== exp_vcyc) begin
        n_fail++; $display("FAIL rnd%0d_drain_cycle: got %0d expected %0d", it, first_vcyc, exp_vcyc);
      end
      for (int i = 0; i < got_n; i++) begin
        n_tests++;
        if (got_b[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_byte[%0d]: got %02h expected %02h", it, i, got_b[i], exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_rise_trigger();
    test_divider();
    test_backpressure();
    test_arm_ignored();
    test_abort();
    test_reset_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
- Upstream acquisition stage for the SSD1306 waveform plotter.
- Samples one selected input channel at a programmable rate, waiting for a trigger first if one is configured.
- Packs 8 samples per byte, MSB = oldest sample, which is the plotter's pixel-byte order.
- Buffers a full screen of samples and then streams the bytes out over a valid/ready interface. The plotter-side driver issues one pixel-data write per accepted byte.

Parameters:
- NUM_BYTES, 16, capture depth in bytes (8*NUM_BYTES samples, 128 = one screen width); power of two, ≥2.
- DIV_W, 16, width of the sample-rate divider.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- sig_in  in  8  already-synchronized probe inputs
- cfg_chan  in  3  channel select into sig_in
- cfg_div  in  DIV_W  sample period minus one, in clk cycles
- cfg_trig  in  2  trigger mode: 00 immediate, 01 rising, 10 falling, 11 any edge
- arm  in  1  single-cycle start pulse
- abort  in  1  single-cycle cancel pulse
- busy  out  1  high in any state except IDLE
- done  out  1  sticky: full capture drained
- out_valid  out  1  output byte valid
- out_data  out  8  output byte
- out_last  out  1  high with the final byte
- out_ready  in  1  consumer accepts byte (plotter idle)

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0. State=IDLE; pointers, divider counter and shift register cleared.
- States: IDLE, WAIT_TRIG, CAPTURE, DRAIN.
- Configuration latch: cfg_chan, cfg_div and cfg_trig are latched on an accepted arm. Changes while busy have no effect.
- IDLE:
  - arm → clears done, latches config, resets wr/rd pointers and the bit counter.
  - Next state: cfg_trig=00 → CAPTURE; otherwise → WAIT_TRIG.
- Edge detection:
  - s = sig_in[chan]; s_d is s registered every cycle, including in IDLE.
  - rise = s & ~s_d; fall = ~s & s_d.
- WAIT_TRIG:
  - On a matching edge, that same cycle counts as sample 0 (value s). Divider counter is loaded with cfg_div.
  - Next state: CAPTURE.
- CAPTURE:
  - Divider counter decrements every cycle. Sample tick when counter==0, then reload with cfg_div. cfg_div=0 → sample every cycle.
  - Immediate mode: the first tick is the cycle after arm.
  - Sample period is exactly cfg_div+1 cycles.
  - Each sample shifts into the LSB of an 8-bit shift register. After 8 samples, the byte is written to buf[wr_ptr] and wr_ptr increments.
  - When byte NUM_BYTES-1 is written → DRAIN. Further samples are not taken.
- DRAIN:
  - out_valid=1; out_data=buf[rd_ptr]; out_last=(rd_ptr==NUM_BYTES-1).
  - out_data and out_last are held stable while out_valid & ~out_ready.
  - On valid & ready: rd_ptr increments. After the last handshake → IDLE, out_valid=0 the next cycle, done=1.
- Simultaneous events and corner cases:
  - abort has priority over everything: any state → IDLE next cycle, out_valid=0, done unchanged (stays 0).
  - arm while busy is ignored.
  - arm and abort in the same cycle in IDLE: abort wins, block stays IDLE.
  - A trigger edge in the arm cycle itself is not detected; WAIT_TRIG evaluates from the following cycle.
- Pointer widths are $clog2(NUM_BYTES). Wrap never occurs, because the state changes at the terminal count.
- Reset mid-operation returns to the reset values above. Buffer contents are not cleared.
- Buffer is a flop array, NUM_BYTES x 8, with a single write port and a single read port.

Decomposition:
- Package waveform_pkg holds:
  - the state enum cap_state_e {IDLE, WAIT_TRIG, CAPTURE, DRAIN}
  - trigger-mode constants TRIG_IMM=2'b00, TRIG_RISE=2'b01, TRIG_FALL=2'b10, TRIG_ANY=2'b11
- Sub-module waveform_sample_timer contains the channel mux, edge detector and divider. Outputs: sample bit, sample tick and trigger hit.
- The FSM, packer, buffer and output interface stay in waveform_capture.

Test Plan:
1. Immediate capture: cfg_trig=00, cfg_div=0, sig_in[2] toggles every cycle, cfg_chan=2, out_ready=1.
   → 16 bytes, all 0xAA or all 0x55 depending on phase; out_last only on byte 15; done=1 afterwards; busy=0.
2. Rising trigger: cfg_trig=01, channel held 0 for 50 cycles, then 1 for 4 cycles, 0 for 4, repeating.
   → no bytes before the edge; first byte = 0xF0 (sample 0 = 1 at the edge).
3. Divider timing: cfg_div=3, immediate mode.
   → consecutive sample ticks exactly 4 cycles apart; first byte written 32 cycles after the first tick's reference point; DRAIN entered after 512 sample cycles.
4. Backpressure: out_ready low for 5 cycles on byte 3, then random.
   → out_data/out_valid held stable while stalled; bytes arrive in order with no duplicates or drops; exactly 16 handshakes.
5. Abort and re-arm:
   - abort mid-CAPTURE, after 5 bytes → IDLE next cycle, done=0, no out_valid.
   - arm pulsed during CAPTURE → ignored.
   - re-arm after abort → a full 16-byte capture completes.
6. Reset mid-DRAIN: rst_n low for 1 cycle at byte 7 → all outputs return to reset values; the next arm starts a clean capture at rd_ptr=0.
